reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Parametrised successor of the board-level power-on reset synchroniser.
- Qualifies an asynchronous lock/ready input (PLL locked) through a configurable synchroniser chain, then holds all resets for a programmable time.
- Releases N_OUT active-low reset outputs one by one, at a fixed stagger interval.
- Adds lock-loss re-sequencing and a soft-reset request/acknowledge handshake.
- Sits at the top of each FPGA image and drives the per-subsystem resets (ADC front-end, FIR, readout, bus interface).

Parameters:
- N_OUT, 4: number of reset outputs; legal 1..16.
- SYNC_STAGES, 3: LOCK synchroniser depth; legal 2..8.
- HOLD_CYCLES, 64: cycles all outputs stay asserted after lock is qualified; legal 1..2^24.
- STAGGER, 8: cycles between successive output releases; legal 1..2^16.

Ports:
- CK  in  1  system clock.
- RSTb  in  1  synchronous active-low reset.
- LOCK  in  1  asynchronous lock/ready qualifier, active-high.
- SOFT_REQ  in  1  synchronous soft-reset request, level or pulse.
- SOFT_ACK  out  1  one-cycle pulse when a soft sequence completes.
- RST_OUTb  out  N_OUT  active-low subsystem resets; bit 0 released first.
- READY  out  1  high when all outputs are released.

Behaviour:
- Clock and reset: one clock, CK. Reset RSTb is synchronous and active-low, sampled on the CK rising edge.
- While RSTb=0:
  - State WAIT_LOCK.
  - RST_OUTb=all 0, READY=0, SOFT_ACK=0.
  - Synchroniser chain cleared to 0; hold_cnt=0, stg_cnt=0, idx=0, soft_flag=0.
- LOCK synchronisation: LOCK passes through SYNC_STAGES flops; lock_s is the last stage. This is the only use of LOCK.
- WAIT_LOCK: on an edge with lock_s=1, go to HOLD with hold_cnt=0.
- HOLD:
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==HOLD_CYCLES-1, go to RELEASE with stg_cnt=0, idx=0. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- RELEASE:
  - stg_cnt increments each edge.
  - On the edge where stg_cnt==STAGGER-1: RST_OUTb[idx] <= 1, stg_cnt <= 0, idx <= idx+1.
  - If idx==N_OUT-1 on that edge, go to RUN and set READY <= 1 on the same edge.
  - Output k releases (k+1)*STAGGER cycles after RELEASE entry.
  - Released bits never re-assert except through the rules below.
- Latency: from the first edge sampling LOCK=1 to RST_OUTb[0]=1 is SYNC_STAGES+1+HOLD_CYCLES+STAGGER edges. READY follows (N_OUT-1)*STAGGER edges later.
- RUN:
  - If lock_s=0: RST_OUTb <= 0, READY <= 0, go to WAIT_LOCK.
  - Else if SOFT_REQ=1: RST_OUTb <= 0, READY <= 0, soft_flag <= 1, go to HOLD with hold_cnt=0. The lock wait is skipped.
  - On entering RUN with soft_flag=1: SOFT_ACK=1 for exactly one cycle, soft_flag cleared.
- Lock loss in HOLD or RELEASE: on the next edge, RST_OUTb <= 0, counters cleared, go to WAIT_LOCK. soft_flag is kept, so SOFT_ACK still fires when the sequence completes.
- SOFT_REQ is ignored outside RUN. A held-high SOFT_REQ re-triggers only after RUN is reached again.
- Simultaneous lock loss and SOFT_REQ in RUN: lock loss wins, soft_flag is still set.
- RSTb=0 mid-sequence overrides everything on that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: RSTSEQ_LOSS_CNT_EN.
- When defined, adds output LOSS_CNT (8 bits).
  - Increments on each edge where RUN is left because of lock_s=0.
  - Saturates at 255; cleared only by RSTb=0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package rstseq_pkg holds:
  - state encoding: WAIT_LOCK=2'd0, HOLD=2'd1, RELEASE=2'd2, RUN=2'd3;
  - default parameter constants;
  - LOSS_CNT width constant (8).
- One natural sub-module, sync_chain: a SYNC_STAGES-deep single-bit synchroniser with synchronous active-low clear. The FSM, counters and outputs stay in reset_sequencer.

Test Plan:
- Defaults. RSTb=0 for 5 cycles, then 1; LOCK=1 from start. Required:
  - RST_OUTb=4'b0000 until edge 76;
  - bit0 at edge 76, bit1 at 84, bit2 at 92, bit3 at 100;
  - READY=1 at edge 100.
- Lock loss in RUN: LOCK drops. Required:
  - after SYNC_STAGES+1 edges, RST_OUTb=0 and READY=0;
  - LOCK restored: the full sequence repeats with identical 76/100-edge timing.
- Soft reset: SOFT_REQ pulse 1 cycle in RUN. Required:
  - next edge RST_OUTb=0;
  - bit0 releases 64+8=72 edges after the request edge;
  - SOFT_ACK is a single-cycle pulse coincident with READY=1, 96 edges after the request edge.
- SOFT_REQ held high during HOLD/RELEASE: ignored; the sequence timing is unchanged.
- RSTb=0 asserted for 1 cycle mid-RELEASE: all outputs are 0 the next edge, and the sequence restarts from WAIT_LOCK.
- RSTSEQ_LOSS_CNT_EN defined, 300 lock losses in RUN: LOSS_CNT=255.

Source files
------------

// File: rtl/rstseq_pkg.sv
// Shared types and defaults for the reset sequencer: state encoding,
// default parameter values and counter widths.
package rstseq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } rstseq_state_t;

  localparam int N_OUT_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 3;
  localparam int HOLD_CYCLES_DEF = 64;
  localparam int STAGGER_DEF     = 8;

  localparam int LOSS_CNT_W = 8;
  // Wide enough for the largest legal HOLD_CYCLES-1 and STAGGER-1.
  localparam int HOLD_CNT_W = 24;
  localparam int STG_CNT_W  = 16;

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Single-bit synchroniser, STAGES flops deep, with synchronous active-low clear.
// Latency STAGES edges; no flow control.
module sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!clr_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Lock-qualified staggered reset release with lock-loss resequencing and soft-reset handshake.
// Bit0 releases SYNC_STAGES+1+HOLD_CYCLES+STAGGER edges after LOCK; no backpressure.
// Optional 8-bit lock-loss counter port LOSS_CNT when RSTSEQ_LOSS_CNT_EN is defined.
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int N_OUT       = N_OUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STAGGER     = STAGGER_DEF
) (
  input  logic             CK,
  input  logic             RSTb,
  input  logic             LOCK,
  input  logic             SOFT_REQ,
  output logic             SOFT_ACK,
  output logic [N_OUT-1:0] RST_OUTb,
`ifdef RSTSEQ_LOSS_CNT_EN
  output logic [LOSS_CNT_W-1:0] LOSS_CNT,
`endif
  output logic             READY
);

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [STG_CNT_W-1:0]  STG_LAST  = STG_CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(N_OUT - 1);

  rstseq_state_t          state;
  logic [HOLD_CNT_W-1:0]  hold_cnt;
  logic [STG_CNT_W-1:0]   stg_cnt;
  logic [IDX_W-1:0]       idx;
  logic                   soft_flag;
  logic                   lock_s;
`ifdef RSTSEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0]  loss_cnt;
  assign LOSS_CNT = loss_cnt;
`endif

  sync_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (CK),
    .clr_n (RSTb),
    .d     (LOCK),
    .q     (lock_s)
  );

  always_ff @(posedge CK) begin
    if (!RSTb) begin
      state     <= WAIT_LOCK;
      RST_OUTb  <= '0;
      READY     <= 1'b0;
      SOFT_ACK  <= 1'b0;
      hold_cnt  <= '0;
      stg_cnt   <= '0;
      idx       <= '0;
      soft_flag <= 1'b0;
`ifdef RSTSEQ_LOSS_CNT_EN
      loss_cnt  <= '0;
`endif
    end else begin
      SOFT_ACK <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD, RELEASE: begin
          // soft_flag survives a lock drop so the pending ACK still fires later.
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            RST_OUTb <= '0;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            idx      <= '0;
          end else if (state == HOLD) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= RELEASE;
              hold_cnt <= '0;
              stg_cnt  <= '0;
              idx      <= '0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
            end
          end else if (stg_cnt == STG_LAST) begin
            RST_OUTb[idx] <= 1'b1;
            stg_cnt       <= '0;
            if (idx == IDX_LAST) begin
              state     <= RUN;
              READY     <= 1'b1;
              SOFT_ACK  <= soft_flag;
              soft_flag <= 1'b0;
              idx       <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            stg_cnt <= stg_cnt + STG_CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            RST_OUTb <= '0;
            READY    <= 1'b0;
            if (SOFT_REQ) soft_flag <= 1'b1;
`ifdef RSTSEQ_LOSS_CNT_EN
            if (loss_cnt != '1) loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
`endif
          end else if (SOFT_REQ) begin
            state     <= HOLD;
            RST_OUTb  <= '0;
            READY     <= 1'b0;
            soft_flag <= 1'b1;
            hold_cnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule
